// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the 32x32 register list: round-robin grant of the single
// write port, registered one-hot write enable/data, and a per-register pending scoreboard.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        wr_stall,
    input  logic                        pend_set,
    input  logic [ADDR_W-1:0]           pend_addr,
    output logic [(1<<ADDR_W)-1:0]      en_out,
    output logic [DATA_W-1:0]           data_wr,
    output logic [(1<<ADDR_W)-1:0]      pending
);

    localparam int                NUM_REGS  = 1 << ADDR_W;
    localparam int                PTR_W     = $clog2(NUM_REQ);
    localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
    localparam logic [NUM_REGS-1:0] REG0_MASK = {{(NUM_REGS-1){1'b1}}, 1'b0};

    // One-hot decode of a register address; register 0 never produces an enable.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] vec;
        vec = {{(NUM_REGS-1){1'b0}}, 1'b1} << addr;
        return vec & REG0_MASK;
    endfunction

    logic [PTR_W-1:0]       ptr_r;
    logic [PTR_W-1:0]       ptr_next_s;
    logic [PTR_W-1:0]       pos_s;
    logic [PTR_W-1:0]       gnt_idx_s;
    logic [PTR_W:0]         sum_s;
    logic [PTR_W:0]         inc_s;
    logic [2*NUM_REQ-1:0]   dbl_s;
    logic [NUM_REQ-1:0]     rot_s;
    logic                   gnt_any_s;
    logic [NUM_REQ-1:0]     gnt_vec_s;
    logic [ADDR_W-1:0]      gnt_addr_s;
    logic [DATA_W-1:0]      gnt_data_s;
    logic [NUM_REGS-1:0]    en_r;
    logic [NUM_REGS-1:0]    en_next_s;
    logic [DATA_W-1:0]      data_r;
    logic [NUM_REGS-1:0]    pend_r;
    logic [NUM_REGS-1:0]    pend_next_s;
    logic [NUM_REGS-1:0]    set_vec_s;

    // Round-robin pick: rotate the valid vector so ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        dbl_s = {req_valid, req_valid} >> ptr_r;
        rot_s = dbl_s[NUM_REQ-1:0];
        pos_s = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos_s = rot_s[k] ? PTR_W'(k) : pos_s;
        end
        sum_s = {1'b0, ptr_r} + {1'b0, pos_s};
        if (sum_s >= NUM_REQ_W) begin
            gnt_idx_s = PTR_W'(sum_s - NUM_REQ_W);
        end else begin
            gnt_idx_s = sum_s[PTR_W-1:0];
        end
        gnt_any_s = (|req_valid) & ~wr_stall & clr_n;
        if (gnt_any_s) begin
            gnt_vec_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s;
        end else begin
            gnt_vec_s = '0;
        end
    end

    // Winner's payload, next pointer and next write-enable vector.
    always_comb begin
        gnt_addr_s = req_addr[gnt_idx_s*ADDR_W +: ADDR_W];
        gnt_data_s = req_data[gnt_idx_s*DATA_W +: DATA_W];
        inc_s      = {1'b0, gnt_idx_s} + {{PTR_W{1'b0}}, 1'b1};
        if (inc_s == NUM_REQ_W) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = inc_s[PTR_W-1:0];
        end
        if (gnt_any_s) begin
            en_next_s = reg_onehot(gnt_addr_s);
        end else begin
            en_next_s = '0;
        end
    end

    assign req_ready = gnt_vec_s;

    // Arbiter pointer and registered write port; an address-0 grant still rotates ptr.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            ptr_r  <= '0;
            en_r   <= '0;
            data_r <= '0;
        end else if (gnt_any_s) begin
            ptr_r  <= ptr_next_s;
            en_r   <= en_next_s;
            data_r <= gnt_data_s;
        end else begin
            ptr_r  <= ptr_r;
            en_r   <= '0;
            data_r <= data_r;
        end
    end

    // A new issue to the same register outranks the write that retires the older producer.
    always_comb begin
        if (pend_set) begin
            set_vec_s = reg_onehot(pend_addr);
        end else begin
            set_vec_s = '0;
        end
        pend_next_s = ((pend_r & ~en_r) | set_vec_s) & REG0_MASK;
    end

    // Pending scoreboard register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

    assign en_out  = en_r;
    assign data_wr = data_r;
    assign pending = pend_r;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a behavioural model checked every negedge,
// plus hand-computed expectations along the stimulus sequence.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;

    logic         clk = 1'b0;
    logic         clr_n;
    logic [2:0]   req_valid;
    logic [14:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         wr_stall;
    logic         pend_set;
    logic [4:0]   pend_addr;
    logic [31:0]  en_out;
    logic [31:0]  data_wr;
    logic [31:0]  pending;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wb_arbiter #(.NUM_REQ(3), .DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .clr_n(clr_n), .req_valid(req_valid), .req_addr(req_addr),
        .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
        .pend_set(pend_set), .pend_addr(pend_addr), .en_out(en_out),
        .data_wr(data_wr), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ptr;
    bit          m_wv;
    bit [4:0]    m_wa;
    bit [31:0]   m_wd;
    bit [31:0]   m_pend;
    int          m_gnt;
    logic [2:0]  m_ready;
    logic [31:0] m_en;

    function automatic int pick(input logic [2:0] v, input int p, input logic s);
        if (s) return -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    always_comb begin
        m_gnt   = pick(req_valid, m_ptr, wr_stall);
        m_ready = (clr_n && m_gnt >= 0) ? (3'b001 << m_gnt) : 3'b000;
        m_en    = (m_wv && m_wa != 5'd0) ? (32'h1 << m_wa) : 32'h0;
    end

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            m_ptr  <= 0;
            m_wv   <= 1'b0;
            m_wa   <= 5'd0;
            m_wd   <= 32'h0;
            m_pend <= 32'h0;
        end else begin
            if (m_gnt >= 0) begin
                m_ptr <= (m_gnt + 1) % NUM_REQ;
                m_wv  <= 1'b1;
                m_wa  <= req_addr[m_gnt*5 +: 5];
                m_wd  <= req_data[m_gnt*32 +: 32];
            end else begin
                m_wv  <= 1'b0;
            end
            for (int b = 1; b < 32; b++) begin
                if (pend_set && pend_addr == 5'(b))
                    m_pend[b] <= 1'b1;
                else if (m_wv && m_wa == 5'(b))
                    m_pend[b] <= 1'b0;
                else
                    m_pend[b] <= m_pend[b];
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_ready",   {29'h0, req_ready}, {29'h0, m_ready});
        check("model_en_out",  en_out,  m_en);
        check("model_data_wr", data_wr, m_wd);
        check("model_pending", pending, m_pend);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic pulse_pend(input logic [4:0] a);
        pend_set  = 1'b1;
        pend_addr = a;
        step();
        pend_set  = 1'b0;
        pend_addr = 5'd0;
    endtask

    initial begin
        clr_n     = 1'b0;
        req_valid = 3'b000;
        req_addr  = 15'h0;
        req_data  = 96'h0;
        wr_stall  = 1'b0;
        pend_set  = 1'b0;
        pend_addr = 5'd0;
        set_req(0, 1'b1, 5'd1, 32'h1111_1111);
        set_req(1, 1'b1, 5'd2, 32'h2222_2222);
        set_req(2, 1'b1, 5'd3, 32'h3333_3333);

        // Reset held with all requesters valid
        repeat (2) @(negedge clk);
        check("rst_ready",   {29'h0, req_ready}, 32'h0);
        check("rst_en_out",  en_out,  32'h0);
        check("rst_data_wr", data_wr, 32'h0);
        check("rst_pending", pending, 32'h0);
        #2 clr_n = 1'b1;
        #1 check("release_first_grant", {29'h0, req_ready}, 32'h1);

        // Round robin with all three continuously valid
        for (int c = 0; c < 6; c++) begin
            check("rr_order", {29'h0, req_ready}, 32'h1 << (c % 3));
            if (c == 1) check("rr_en_req0", en_out, 32'h0000_0002);
            step();
        end
        req_valid = 3'b000;

        // Single write from req1
        set_req(1, 1'b1, 5'd7, 32'hDEAD_BEEF);
        #1 check("single_ready", {29'h0, req_ready}, 32'h2);
        step();
        req_valid[1] = 1'b0;
        check("single_en_t1",   en_out,  32'h0000_0080);
        check("single_data_t1", data_wr, 32'hDEAD_BEEF);
        step();
        check("single_en_t2", en_out, 32'h0);

        // Address 0 from req2: accepted, discarded, ptr rotates
        set_req(2, 1'b1, 5'd0, 32'h1234_5678);
        #1 check("addr0_ready", {29'h0, req_ready}, 32'h4);
        step();
        req_valid[2] = 1'b0;
        check("addr0_en", en_out, 32'h0);
        set_req(1, 1'b1, 5'd3, 32'hAAAA_0001);
        set_req(2, 1'b1, 5'd4, 32'hAAAA_0002);
        #1 check("addr0_ptr_advanced", {29'h0, req_ready}, 32'h2);
        step();
        req_valid[1] = 1'b0;
        check("b2b_en_req1", en_out, 32'h0000_0008);
        check("b2b_ready_req2", {29'h0, req_ready}, 32'h4);
        step();
        req_valid[2] = 1'b0;
        check("b2b_en_req2", en_out, 32'h0000_0010);
        check("b2b_data_req2", data_wr, 32'hAAAA_0002);

        // Stall for two cycles with req0 waiting
        wr_stall = 1'b1;
        set_req(0, 1'b1, 5'd9, 32'hA5A5_A5A5);
        #1 check("stall_ready_c0", {29'h0, req_ready}, 32'h0);
        step();
        check("stall_ready_c1", {29'h0, req_ready}, 32'h0);
        check("stall_en_c1", en_out, 32'h0);
        step();
        wr_stall = 1'b0;
        #1 check("stall_release_ready", {29'h0, req_ready}, 32'h1);
        step();
        req_valid[0] = 1'b0;
        check("stall_en", en_out, 32'h0000_0200);

        // Scoreboard set then clear by write
        pulse_pend(5'd5);
        check("pend_set5", pending, 32'h0000_0020);
        set_req(0, 1'b1, 5'd5, 32'h0000_0055);
        step();
        req_valid[0] = 1'b0;
        check("pend_clr_en", en_out, 32'h0000_0020);
        check("pend_still_set", pending, 32'h0000_0020);
        step();
        check("pend_cleared", pending, 32'h0);

        // Set wins over clear on the same edge
        pulse_pend(5'd5);
        set_req(1, 1'b1, 5'd5, 32'h0000_0066);
        step();
        req_valid[1] = 1'b0;
        check("setwin_en", en_out, 32'h0000_0020);
        pulse_pend(5'd5);
        check("setwin_pending", pending, 32'h0000_0020);

        // pend_set to register 0 is ignored
        pulse_pend(5'd0);
        check("pend_addr0", pending, 32'h0000_0020);
        set_req(2, 1'b1, 5'd5, 32'h0000_0077);
        step();
        req_valid[2] = 1'b0;
        step();
        check("pend_cleared_again", pending, 32'h0);

        // Asynchronous reset in the middle of a write
        pulse_pend(5'd10);
        pulse_pend(5'd11);
        set_req(0, 1'b1, 5'd10, 32'hCAFE_F00D);
        step();
        set_req(0, 1'b1, 5'd1, 32'h1111_1111);
        set_req(1, 1'b1, 5'd2, 32'h2222_2222);
        set_req(2, 1'b1, 5'd3, 32'h3333_3333);
        check("midrst_en_before", en_out, 32'h0000_0400);
        check("midrst_pend_before", pending, 32'h0000_0C00);
        #2 clr_n = 1'b0;
        #1;
        check("midrst_en",      en_out,  32'h0);
        check("midrst_pending", pending, 32'h0);
        check("midrst_data",    data_wr, 32'h0);
        check("midrst_ready",   {29'h0, req_ready}, 32'h0);
        @(negedge clk);
        #2 clr_n = 1'b1;
        #1 check("midrst_ptr0", {29'h0, req_ready}, 32'h1);
        step();
        check("midrst_first_write", en_out, 32'h0000_0002);
        req_valid = 3'b000;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the 32×32 register list between several writeback requesters (ALU, load, mult/div) with a round-robin arbiter and valid/ready handshake. It drives the register list's one-hot write-enable vector and write data from registered outputs. It also keeps a per-register pending scoreboard that the issue stage uses for hazard checks. It sits between the writeback sources and the register list; register 0 is never enabled and never pending.

## Interface
Parameters:
- NUM_REQ, 3: number of writeback requesters (2..8)
- DATA_W, 32: register data width
- ADDR_W, 5: register address width (32 registers)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- clr_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_addr  in  NUM_REQ*ADDR_W  destination of requester i, slice i
- req_data  in  NUM_REQ*DATA_W  write data of requester i, slice i
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted this cycle
- wr_stall  in  1  blocks all grants this cycle
- pend_set  in  1  issue stage marks a destination pending
- pend_addr  in  ADDR_W  register to mark pending
- en_out  out  32  one-hot write enable to the register list; bit 0 always 0
- data_wr  out  DATA_W  write data to the register list
- pending  out  32  scoreboard; bit 0 always 0

## Operation
- Handshake: a requester raises req_valid and holds it, along with addr and data, stable until it sees req_ready high at a rising edge. The transfer occurs on the cycle where valid and ready are both high. A requester may not drop valid before acceptance.
- req_ready is combinational from req_valid, the rotation pointer and wr_stall. At most one bit is set, and it is only set when the matching valid is high and wr_stall is 0.
- Arbitration is round-robin. Pointer ptr (0..NUM_REQ-1) names the highest-priority requester. Priority descends ptr, ptr+1, … modulo NUM_REQ. After a grant to i, ptr becomes (i+1) mod NUM_REQ. With no grant, ptr is unchanged.
- Write output is registered. On a grant, en_out gets a one-hot at req_addr[i] and data_wr gets req_data[i]. With no grant, en_out is 0 and data_wr holds its previous value.
- Address 0: the request is arbitrated and accepted normally and rotates ptr. en_out stays all zero, so the write is discarded.
- Scoreboard:
  - pend_set sets pending[pend_addr]. pend_addr 0 is ignored.
  - A bit clears on the edge where en_out has that bit set, which is the same edge the register list captures the data.
  - If a set and a clear hit the same address on the same edge, the set wins because a newer producer has been issued.
  - Bits for other addresses are unaffected.
- Reset (clr_n low, asynchronous, at any time):
  - ptr = 0, en_out = 0, data_wr = 0, pending = 0.
  - req_ready is forced to 0 while clr_n is low.
  - A registered write in flight is dropped.

## Timing
- Grant in cycle t → en_out/data_wr valid in cycle t+1 → register list updated at the end of t+1. Write latency is 2 edges from acceptance to data in the register.
- pending bit drops at the end of t+1, the same edge as the register update. A read in t+2 returns the new value.
- Throughput is one write per cycle. Back-to-back grants to different requesters are allowed.
- wr_stall high in cycle t gives no grant in t and en_out = 0 in t+1. ptr is unchanged.
- Worst-case wait for a held request is NUM_REQ-1 grants with no stall (no starvation).
- clr_n deassertion is synchronous-safe. First grant is possible in the first cycle after release.

## Test plan
- Reset: hold clr_n low with all req_valid high → req_ready = 0, en_out = 0, data_wr = 0, pending = 0. Release → req0 is granted first.
- Single write: req1 with addr 7, data 0xDEADBEEF, granted in cycle t → in t+1, en_out = 0x00000080 and data_wr = 0xDEADBEEF. In t+2, en_out = 0.
- Round-robin: all three requesters valid continuously → grants in order 0,1,2,0,1,2. Each ready is high for exactly one cycle per round.
- Addr 0 and stall:
  - req2 to addr 0 → accepted, en_out = 0, ptr advances.
  - wr_stall high for 2 cycles with req0 valid → no ready. req0 is granted in the cycle stall drops.
- Scoreboard:
  - pend_set addr 5 → pending = 0x20. Grant write to 5 → bit clears one edge after en_out shows 0x20.
  - pend_set 5 on the same edge as that write → pending[5] stays 1.
  - pend_set addr 0 → pending unchanged.
- Reset mid-operation: assert clr_n low while en_out = 0x00000400 and pending = 0x00000C00 → both go to 0 immediately (asynchronous). ptr returns to 0.
